// File: rtl/sutun_karistirma_seri_if.sv
// Handshake bundle for sutun_karistirma_seri; the ters line exists only when
// TERS_KARISTIRMA_EN is defined.
interface sutun_karistirma_seri_if;
    logic         giris_gecerli;
    logic         giris_hazir;
    logic [127:0] matris;
    logic         son_tur;
`ifdef TERS_KARISTIRMA_EN
    logic         ters;
`endif
    logic         cikis_gecerli;
    logic         cikis_hazir;
    logic [127:0] karistirilmis_matris;

    modport master (
`ifdef TERS_KARISTIRMA_EN
        output ters,
`endif
        output giris_gecerli,
        input  giris_hazir,
        output matris,
        output son_tur,
        input  cikis_gecerli,
        output cikis_hazir,
        input  karistirilmis_matris
    );

    modport slave (
`ifdef TERS_KARISTIRMA_EN
        input  ters,
`endif
        input  giris_gecerli,
        output giris_hazir,
        input  matris,
        input  son_tur,
        output cikis_gecerli,
        input  cikis_hazir,
        output karistirilmis_matris
    );
endinterface

// File: rtl/sutun_karistirma_seri.sv
// AES MixColumns stage that mixes SUTUN_ADET columns per clock, with a final-round bypass.
// Optional macro TERS_KARISTIRMA_EN adds the ters input, which selects InvMixColumns.
module sutun_karistirma_seri #(
    parameter int unsigned SUTUN_ADET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sutun_karistirma_seri_if.slave bag
);
    typedef enum logic [1:0] {
        BOS   = 2'd0,
        ISLE  = 2'd1,
        CIKIS = 2'd2
    } durum_t;

    durum_t           r_durum;
    logic [2:0]       r_sayac;
    logic [0:3][31:0] r_giris;
    logic [0:3][31:0] r_sonuc;
    logic             r_son;
    logic             r_gecerli;
    logic             r_hazir;
`ifdef TERS_KARISTIRMA_EN
    logic             r_ters;
`endif

    logic [1:0]  w_idx   [SUTUN_ADET];
    logic [31:0] w_sutun [SUTUN_ADET];
    logic        w_son_adim;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] ileri(input logic [31:0] s);
        logic [7:0] a [4];
        logic [7:0] m2 [4];
        logic [7:0] m3 [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = s[31 - 8*i -: 8];
            m2[i] = xtime(a[i]);
            m3[i] = m2[i] ^ a[i];
        end
        return {m2[0] ^ m3[1] ^ a[2]  ^ a[3],
                a[0]  ^ m2[1] ^ m3[2] ^ a[3],
                a[0]  ^ a[1]  ^ m2[2] ^ m3[3],
                m3[0] ^ a[1]  ^ a[2]  ^ m2[3]};
    endfunction

`ifdef TERS_KARISTIRMA_EN
    function automatic logic [31:0] geri(input logic [31:0] s);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int unsigned i = 0; i < 4; i++) begin
            a[i]  = s[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction
`endif

    // Only SUTUN_ADET mixers exist; the counter steers which captured columns feed them.
    always_comb begin
        for (int unsigned j = 0; j < SUTUN_ADET; j++) begin
            w_idx[j]   = r_sayac[1:0] + 2'(j);
            w_sutun[j] = r_giris[w_idx[j]];
            if (!r_son) begin
`ifdef TERS_KARISTIRMA_EN
                w_sutun[j] = r_ters ? geri(r_giris[w_idx[j]]) : ileri(r_giris[w_idx[j]]);
`else
                w_sutun[j] = ileri(r_giris[w_idx[j]]);
`endif
            end
        end
    end

    assign w_son_adim = ((r_sayac + 3'(SUTUN_ADET)) == 3'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_durum   <= BOS;
            r_sayac   <= '0;
            r_giris   <= '0;
            r_sonuc   <= '0;
            r_son     <= 1'b0;
            r_gecerli <= 1'b0;
            r_hazir   <= 1'b1;
`ifdef TERS_KARISTIRMA_EN
            r_ters    <= 1'b0;
`endif
        end else begin
            case (r_durum)
                BOS: begin
                    if (bag.giris_gecerli) begin
                        r_giris <= bag.matris;
                        r_son   <= bag.son_tur;
`ifdef TERS_KARISTIRMA_EN
                        r_ters  <= bag.ters;
`endif
                        r_sayac <= '0;
                        r_hazir <= 1'b0;
                        r_durum <= ISLE;
                    end
                end
                ISLE: begin
                    for (int unsigned j = 0; j < SUTUN_ADET; j++) begin
                        r_sonuc[w_idx[j]] <= w_sutun[j];
                    end
                    r_sayac <= r_sayac + 3'(SUTUN_ADET);
                    if (w_son_adim) begin
                        r_gecerli <= 1'b1;
                        r_durum   <= CIKIS;
                    end
                end
                CIKIS: begin
                    if (bag.cikis_hazir) begin
                        r_gecerli <= 1'b0;
                        r_hazir   <= 1'b1;
                        r_durum   <= BOS;
                    end
                end
                default: begin
                    r_gecerli <= 1'b0;
                    r_hazir   <= 1'b1;
                    r_durum   <= BOS;
                end
            endcase
        end
    end

    assign bag.giris_hazir          = r_hazir;
    assign bag.cikis_gecerli        = r_gecerli;
    assign bag.karistirilmis_matris = r_sonuc;
endmodule

// File: doc/sutun_karistirma_seri.md
Name: sutun_karistirma_seri

Overview:
- AES MixColumns stage, placed directly downstream of the row-shift stage. It consumes the 128-bit shifted state.
- Processes SUTUN_ADET columns per clock through a valid/ready handshake and holds the result in a registered output.
- Final-round bypass: the state passes unchanged, with the same latency.

Parameters:
SUTUN_ADET, 1, columns mixed per clock; legal values 1, 2, 4; processing cycles P = 4/SUTUN_ADET

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
giris_gecerli  input  1  input state valid
giris_hazir  output  1  block can accept a state
matris  input  128  state; word [127:96] is column 0 … [31:0] is column 3; byte [31:24] of a word is row 0
son_tur  input  1  final round; state is passed unmixed; sampled with matris
cikis_gecerli  output  1  karistirilmis_matris valid
cikis_hazir  input  1  downstream accepts result
karistirilmis_matris  output  128  mixed state, same layout as matris

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to BOS; column counter = 0.
  - giris_hazir=1 after reset; cikis_gecerli=0; karistirilmis_matris=0.
  - Any in-flight state is discarded, including mid-ISLE and mid-CIKIS.
- FSM states:
  - BOS (idle):
    - giris_hazir=1.
    - On giris_gecerli=1 at edge k: capture matris and son_tur, counter=0, go to ISLE.
  - ISLE:
    - giris_hazir=0.
    - Each edge mixes columns counter .. counter+SUTUN_ADET-1 into the result register; counter += SUTUN_ADET.
    - After the P-th ISLE edge (edge k+P): go to CIKIS with cikis_gecerli=1.
  - CIKIS:
    - Output held stable while cikis_hazir=0.
    - Edge with cikis_hazir=1: cikis_gecerli=0, go to BOS.
    - No input is accepted in the same cycle, so the minimum period between accepts is P+2 cycles.
- Latency: accept edge k → cikis_gecerli high after edge k+P (P=4 at default). It is identical when son_tur=1.
- giris_gecerli is ignored outside BOS; matris is captured only at accept, so changes after accept have no effect.
- Column math, GF(2^8) with polynomial 0x11B:
  - Input column bytes a0..a3; xtime(x) = (x<<1) ^ (x[7] ? 0x1B : 0), 8-bit result.
  - b0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - b1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - b2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - b3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - 3x = xtime(x) ^ x. No multipliers; XOR/xtime only.
- son_tur=1: each column slot is loaded with the captured input column instead of the mixed one; same schedule.
- Counter wraps to 0 on entry to ISLE only; no wrap within a transaction.
- cikis_hazir may be high before cikis_gecerli; it has no effect outside CIKIS.
- Simultaneous rst and any handshake: rst wins.

Optional Feature:
- Macro: TERS_KARISTIRMA_EN.
- When defined:
  - Extra input port ters (1 bit), sampled at accept together with son_tur.
  - ters=1 selects InvMixColumns with coefficients 0e, 0b, 0d, 09 (row 0: 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3, rotated per row), built from chained xtime.
  - Latency is unchanged.
  - son_tur=1 bypasses regardless of ters.
- When undefined: no ters port, forward MixColumns only, no inverse logic synthesized.

Test Plan:
1. FIPS-197 round 1, son_tur=0, SUTUN_ADET=1: matris=d4bf5d30e0b452aeb84111f11e2798e5 → after 4 cycles, cikis_gecerli=1 with output 046681e5e0cb199a48f8d37a2806264c.
2. Column vectors: matris=db135345f20a225c01010101c6c6c6c6 → 8e4da1bc9fdc589d01010101c6c6c6c6. Repeat with SUTUN_ADET=2 (latency 2) and SUTUN_ADET=4 (latency 1); outputs identical.
3. Bypass: son_tur=1, matris=d4d4d4d52d26314c0123456789abcdef → identical output after P cycles. Then son_tur=0 on the same state → d5d5d7d64d7ebdf8 in columns 0–1.
4. Backpressure: hold cikis_hazir=0 for 10 cycles after valid → output stable, giris_hazir=0, a new giris_gecerli is ignored. Release → exactly one transfer, then giris_hazir=1 on the next cycle.
5. Reset mid-ISLE (edge k+2) → next cycle giris_hazir=1, cikis_gecerli=0, output 0. A new state accepted afterwards produces its correct result with no corruption.
6. With TERS_KARISTIRMA_EN: ters=1, matris=046681e5e0cb199a48f8d37a2806264c → d4bf5d30e0b452aeb84111f11e2798e5.
